// File: rtl/kb_pkg.sv
// kb_pkg: shared constants and types for the PS/2 keyboard event decoder.
// Holds the scan-code bytes the decoder acts on, the FSM state encoding
// and the layout of one queued key event.
package kb_pkg;

    localparam int CODE_W  = 8;
    localparam int ENTRY_W = 10;

    // Prefix bytes
    localparam logic [7:0] BRK = 8'hF0;
    localparam logic [7:0] EXT = 8'hE0;

    // Protocol/status bytes that never become key events
    localparam logic [7:0] KB_NUL     = 8'h00;
    localparam logic [7:0] KB_BAT_OK  = 8'hAA;
    localparam logic [7:0] KB_PAUSE   = 8'hE1;
    localparam logic [7:0] KB_ECHO    = 8'hEE;
    localparam logic [7:0] KB_ACK     = 8'hFA;
    localparam logic [7:0] KB_BAT_ERR = 8'hFC;
    localparam logic [7:0] KB_ERR_FD  = 8'hFD;
    localparam logic [7:0] KB_RESEND  = 8'hFE;
    localparam logic [7:0] KB_OVERRUN = 8'hFF;

    // Decoder FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } kb_event_t;

    function automatic logic is_discard(input logic [7:0] b);
        logic r;
        case (b)
            KB_NUL, KB_BAT_OK, KB_PAUSE, KB_ECHO, KB_ACK,
            KB_BAT_ERR, KB_ERR_FD, KB_RESEND, KB_OVERRUN: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/kb_event_decoder_if.sv
// kb_event_decoder_if: PS/2 line inputs, CPU-side read/clear strobes and
// the head-of-queue event outputs. The decoder is the slave side.
interface kb_event_decoder_if;
    import kb_pkg::*;

    logic              ps2d;
    logic              ps2c;
    logic              rd_key;
    logic              clr_ovf;
    logic [CODE_W-1:0] key_code;
    logic              key_ext;
    logic              key_brk;
    logic              kb_buf_empty;
    logic              kb_buf_full;
    logic              overflow;
    logic              interrupt;

    modport master (
        output ps2d, ps2c, rd_key, clr_ovf,
        input  key_code, key_ext, key_brk, kb_buf_empty, kb_buf_full,
               overflow, interrupt
    );

    modport slave (
        input  ps2d, ps2c, rd_key, clr_ovf,
        output key_code, key_ext, key_brk, kb_buf_empty, kb_buf_full,
               overflow, interrupt
    );

endinterface

// File: rtl/kb_event_fifo.sv
// kb_event_fifo: first-word-fall-through queue of 2**W_SIZE entries.
// A push when full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and o_drop pulses. A pop when empty is ignored.
// o_data reads as zero while empty.
module kb_event_fifo #(
    parameter int W_SIZE = 2,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_drop
);

    localparam int DEPTH = 2 ** W_SIZE;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [W_SIZE-1:0] r_wr_ptr;
    logic [W_SIZE-1:0] r_rd_ptr;
    logic [W_SIZE:0]   r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (W_SIZE+1)'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage write; contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally at 2**W_SIZE; count tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_drop  = i_push && !w_do_push;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host byte receiver. The PS/2 clock is debounced
// by an 8-sample filter; data is sampled on each filtered falling edge.
// One 11-bit frame (start, 8 data LSB first, parity, stop) produces a
// single-cycle o_rx_done_tick with the byte on o_dout. Parity is not checked.
module ps2_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2d,
    input  logic       i_ps2c,
    input  logic       i_rx_en,
    output logic       o_rx_done_tick,
    output logic [7:0] o_dout
);

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_DPS  = 2'd1;
    localparam logic [1:0] RX_LOAD = 2'd2;

    logic [7:0] r_filter;
    logic       r_fps2c;
    logic       r_fps2c_d;
    logic [1:0] r_ps2d_sync;
    logic       w_fall;
    logic [1:0] r_rx_state;
    logic [3:0] r_n;
    logic [9:0] r_b;

    // Debounce PS/2 clock and resynchronise the data line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filter    <= '0;
            r_fps2c     <= 1'b0;
            r_fps2c_d   <= 1'b0;
            r_ps2d_sync <= 2'b11;
        end else begin
            r_filter    <= {i_ps2c, r_filter[7:1]};
            if (r_filter == 8'hFF)
                r_fps2c <= 1'b1;
            else if (r_filter == 8'h00)
                r_fps2c <= 1'b0;
            r_fps2c_d   <= r_fps2c;
            r_ps2d_sync <= {i_ps2d, r_ps2d_sync[1]};
        end
    end

    assign w_fall = r_fps2c_d & ~r_fps2c;

    // Frame shifter: the start bit falls off the bottom, leaving stop/parity/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_n        <= '0;
            r_b        <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_fall && i_rx_en) begin
                        r_b        <= {r_ps2d_sync[0], r_b[9:1]};
                        r_n        <= 4'd9;
                        r_rx_state <= RX_DPS;
                    end
                end
                RX_DPS: begin
                    if (w_fall) begin
                        r_b <= {r_ps2d_sync[0], r_b[9:1]};
                        if (r_n == 4'd0)
                            r_rx_state <= RX_LOAD;
                        else
                            r_n <= r_n - 4'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign o_rx_done_tick = (r_rx_state == RX_LOAD);
    assign o_dout         = r_b[7:0];

endmodule

// File: rtl/kb_event_decoder.sv
// kb_event_decoder: turns PS/2 scan-code bytes into {ext, brk, code} key
// events and queues them for the CPU. Handles E0 / F0 prefixes, drops
// protocol bytes, abandons a stalled prefix after TO_CYCLES idle cycles,
// and flags queue overflow (sticky until clr_ovf; a new drop wins).
// Optional build macro KB_TYPEMATIC_FILTER_EN suppresses repeated make
// events for a held key.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no prefix pending; plain make codes push directly
// ST_EXT     | E0 seen; next code is an extended make (or F0)
// ST_BRK     | F0 seen; next code is a plain release
// ST_EXT_BRK | E0 F0 seen; next code is an extended release
module kb_event_decoder
    import kb_pkg::*;
#(
    parameter int W_SIZE    = 2,
    parameter int TO_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    kb_event_decoder_if.slave bus
);

    localparam int              TO_W    = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic            w_rx_tick;
    logic [7:0]      w_rx_byte;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    kb_event_t       w_ev;
    logic            w_ev_vld;
    logic            w_push;
    kb_event_t       w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_drop;
    logic            r_overflow;

    ps2_rx u_ps2_rx (
        .clk            (clk),
        .reset          (reset),
        .i_ps2d         (bus.ps2d),
        .i_ps2c         (bus.ps2c),
        .i_rx_en        (1'b1),
        .o_rx_done_tick (w_rx_tick),
        .o_dout         (w_rx_byte)
    );

    assign w_timeout = (r_state != ST_IDLE) && !w_rx_tick && (r_to_cnt == TO_LAST);

    // Next-state and event decode for each received byte
    always_comb begin
        w_state_nxt = r_state;
        w_ev_vld    = 1'b0;
        w_ev        = '{ext: 1'b0, brk: 1'b0, code: w_rx_byte};
        case (r_state)
            ST_IDLE: begin
                if (w_rx_tick) begin
                    if (w_rx_byte == EXT)
                        w_state_nxt = ST_EXT;
                    else if (w_rx_byte == BRK)
                        w_state_nxt = ST_BRK;
                    else if (!is_discard(w_rx_byte))
                        w_ev_vld = 1'b1;
                end
            end
            ST_EXT: begin
                if (w_rx_tick) begin
                    if (w_rx_byte == BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (w_rx_byte != EXT) begin
                        w_ev_vld    = 1'b1;
                        w_ev.ext    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BRK: begin
                if (w_rx_tick) begin
                    w_ev_vld    = 1'b1;
                    w_ev.brk    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (w_rx_tick) begin
                    w_ev_vld    = 1'b1;
                    w_ev.ext    = 1'b1;
                    w_ev.brk    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Decoder state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Prefix stall counter: runs only while a prefix is pending with no byte arriving
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_to_cnt <= '0;
        else if (r_state == ST_IDLE || w_rx_tick || w_timeout)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

`ifdef KB_TYPEMATIC_FILTER_EN
    logic [8:0] r_last;
    logic       r_last_vld;
    logic       w_same;

    assign w_same = r_last_vld && (r_last == {w_ev.ext, w_ev.code});
    assign w_push = w_ev_vld && (w_ev.brk || !w_same);

    // Remember the last make so a held key's repeats are swallowed until released
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_ev_vld) begin
            if (!w_ev.brk) begin
                r_last     <= {w_ev.ext, w_ev.code};
                r_last_vld <= 1'b1;
            end else if (w_same) begin
                r_last_vld <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_ev_vld;
`endif

    kb_event_fifo #(
        .W_SIZE (W_SIZE),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (bus.rd_key),
        .i_data  (w_ev),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    // Sticky overflow; a fresh drop takes priority over a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
        else if (bus.clr_ovf)
            r_overflow <= 1'b0;
    end

    assign bus.key_code     = w_head.code;
    assign bus.key_ext      = w_head.ext;
    assign bus.key_brk      = w_head.brk;
    assign bus.kb_buf_empty = w_empty;
    assign bus.kb_buf_full  = w_full;
    assign bus.overflow     = r_overflow;
    assign bus.interrupt    = ~w_empty;

endmodule
